// File: rtl/mult_round_sat_pkg.sv
// Shared widths, output limits and the round-half-up / saturate helper for
// product scaling stages.
package mult_round_sat_pkg;

  localparam int PROD_W         = 40;
  localparam int OUT_W          = 24;
  localparam int SHIFT_W        = 4;
  localparam int MULT_LAT_DEF   = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } sample_t;

  typedef struct packed {
    logic               valid;
    logic [SHIFT_W-1:0] shift;
  } tag_t;

  // One extra bit of headroom keeps the rounding add from wrapping at the
  // largest positive product.
  function automatic sample_t round_sat(input logic [PROD_W-1:0]  prod,
                                        input logic [SHIFT_W-1:0] sh);
    logic signed [PROD_W:0]       ext;
    logic signed [PROD_W:0]       half;
    logic signed [PROD_W:0]       v;
    logic [PROD_W-OUT_W+1:0]      top;
    sample_t                      r;
    ext  = $signed({prod[PROD_W-1], prod});
    half = '0;
    if (sh != '0) half = $signed((PROD_W+1)'(1) << (sh - 1'b1));
    v    = (ext + half) >>> sh;
    top  = v[PROD_W:OUT_W-1];
    if (!v[PROD_W] && (|top)) begin
      r.sat  = 1'b1;
      r.data = OUT_MAX;
    end else if (v[PROD_W] && !(&top)) begin
      r.sat  = 1'b1;
      r.data = OUT_MIN;
    end else begin
      r.sat  = 1'b0;
      r.data = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; the read port holds the last popped
// word while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [WIDTH-1:0] last_q;
  logic             push;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign level = count;
  assign pop   = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/mult_round_sat.sv
// Multiplier back end: tag tracking, round/saturate to 24 bits and a small
// output FIFO with drop accounting.
module mult_round_sat
  import mult_round_sat_pkg::*;
#(
  parameter int MULT_LAT   = MULT_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [SHIFT_W-1:0]            shift,
  input  logic [PROD_W-1:0]             product,
  input  logic                          ovf_clr,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sat,
  output logic                          ovf_sticky,
  output logic [CNT_W-1:0]              drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  tag_t    tag_q [MULT_LAT];
  logic    s1_valid_q;
  sample_t s1_q;
  logic    wr_valid_q;
  sample_t wr_q;
  sample_t head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    drop;

  // The last tag register lines up with the multiplier output stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MULT_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: in_valid, shift: shift};
      for (int i = 1; i < MULT_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      wr_valid_q <= 1'b0;
      wr_q       <= '0;
    end else begin
      s1_valid_q <= tag_q[MULT_LAT-1].valid;
      if (tag_q[MULT_LAT-1].valid) s1_q <= round_sat(product, tag_q[MULT_LAT-1].shift);
      wr_valid_q <= s1_valid_q;
      if (s1_valid_q) wr_q <= s1_q;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_valid_q),
    .wr_data (wr_q),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_sat   = head.sat;
  assign drop      = wr_valid_q && fifo_full && !(out_valid && out_ready);

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (ovf_clr)                   drop_count <= CNT_W'(1);
      else if (drop_count != CNT_MAX) drop_count <= drop_count + 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_mult_round_sat.sv
// Directed and random checks of mult_round_sat against a queue-based
// reference model of the scaling rules and output buffer.
module tb_mult_round_sat;
  import mult_round_sat_pkg::*;

  localparam int MULT_LAT   = MULT_LAT_DEF;
  localparam int FIFO_DEPTH = FIFO_DEPTH_DEF;
  localparam int CNT_W      = CNT_W_DEF;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int PIPE       = MULT_LAT + 2;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [SHIFT_W-1:0] shift = '0;
  logic [PROD_W-1:0]  prod_in = '0;
  logic [PROD_W-1:0]  product;
  logic               ovf_clr = 1'b0;
  logic               out_ready = 1'b0;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_sat;
  logic               ovf_sticky;
  logic [CNT_W-1:0]   drop_count;
  logic [LVL_W-1:0]   fifo_level;

  logic [PROD_W-1:0]  mult_pipe [MULT_LAT];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } exp_t;

  exp_t   q[$];
  logic   line_v [PIPE];
  exp_t   line_s [PIPE];
  longint m_drops;
  logic   m_sticky;
  exp_t   m_last;

  mult_round_sat dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .shift      (shift),
    .product    (product),
    .ovf_clr    (ovf_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sat    (out_sat),
    .ovf_sticky (ovf_sticky),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  // Stand-in for the upstream multiplier: the value presented with in_valid
  // emerges MULT_LAT clocks later.
  always @(posedge clock) begin
    mult_pipe[0] <= prod_in;
    for (int i = 1; i < MULT_LAT; i++) mult_pipe[i] <= mult_pipe[i-1];
  end
  assign product = mult_pipe[MULT_LAT-1];

  function automatic exp_t ref_scale(logic [PROD_W-1:0] p, int sh);
    longint v;
    exp_t   r;
    v = longint'($signed(p));
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > (longint'(1) << (OUT_W - 1)) - 1) begin
      r.sat = 1'b1; r.data = 24'h7FFFFF;
    end else if (v < -(longint'(1) << (OUT_W - 1))) begin
      r.sat = 1'b1; r.data = 24'h800000;
    end else begin
      r.sat = 1'b0; r.data = v[OUT_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [PROD_W-1:0] rand_prod();
    logic [63:0]               r;
    logic signed [PROD_W-1:0]  p;
    r = {$urandom, $urandom};
    p = r[PROD_W-1:0];
    p = p >>> $urandom_range(0, 36);
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < PIPE; i++) begin
      line_v[i] = 1'b0;
      line_s[i] = '0;
    end
    m_drops  = 0;
    m_sticky = 1'b0;
    m_last   = '0;
  endtask

  // Applies the current inputs to the model as the next rising edge would.
  task automatic model_edge();
    logic arr_v;
    exp_t arr;
    bit   pop;
    bit   drp;
    arr_v = line_v[PIPE-1];
    arr   = line_s[PIPE-1];
    for (int i = PIPE - 1; i > 0; i--) begin
      line_v[i] = line_v[i-1];
      line_s[i] = line_s[i-1];
    end
    line_v[0] = in_valid;
    line_s[0] = ref_scale(prod_in, int'(shift));
    pop = (q.size() > 0) && out_ready;
    drp = arr_v && (q.size() == FIFO_DEPTH) && !pop;
    if (pop) m_last = q.pop_front();
    if (arr_v && !drp) q.push_back(arr);
    if (drp) begin
      m_sticky = 1'b1;
      if (ovf_clr) m_drops = 1;
      else if (m_drops < CNT_MAX) m_drops = m_drops + 1;
    end else if (ovf_clr) begin
      m_sticky = 1'b0;
      m_drops  = 0;
    end
  endtask

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    exp_t h;
    h = (q.size() > 0) ? q[0] : m_last;
    chk({tag, ":out_valid"},  64'(out_valid),  64'(q.size() > 0));
    chk({tag, ":out_data"},   64'(out_data),   64'(h.data));
    chk({tag, ":out_sat"},    64'(out_sat),    64'(h.sat));
    chk({tag, ":fifo_level"}, 64'(fifo_level), 64'(q.size()));
    chk({tag, ":drop_count"}, 64'(drop_count), 64'(m_drops));
    chk({tag, ":ovf_sticky"}, 64'(ovf_sticky), 64'(m_sticky));
  endtask

  task automatic cycle(string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic send(string tag, logic [PROD_W-1:0] p, logic [SHIFT_W-1:0] sh);
    in_valid = 1'b1;
    prod_in  = p;
    shift    = sh;
    cycle(tag);
    in_valid = 1'b0;
    prod_in  = '0;
  endtask

  // Waits (bounded) for a head sample and checks it against fixed values.
  task automatic wait_head(string tag, logic [OUT_W-1:0] data, logic sat, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      cycle(tag);
      lat++;
    end
    if (out_valid) begin
      chk({tag, ":data"}, 64'(out_data), 64'(data));
      chk({tag, ":sat"},  64'(out_sat),  64'(sat));
    end else begin
      chk({tag, ":timeout"}, 64'(0), 64'(1));
    end
  endtask

  initial begin
    int  lat;
    bit  raised;

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("por");
    reset_n = 1'b1;
    out_ready = 1'b1;
    cycle("idle");

    send("lat", 40'h00_0012_3456, 4'd0);
    wait_head("lat", 24'h123456, 1'b0, lat);
    chk("lat:clocks", 64'(lat), 64'(6));

    send("rnd_pos", 40'h00_0000_0180, 4'd8);
    wait_head("rnd_pos", 24'h000002, 1'b0, lat);
    send("rnd_neg", 40'hFF_FFFF_FE80, 4'd8);
    wait_head("rnd_neg", 24'hFFFFFF, 1'b0, lat);

    send("sat_pos", 40'h00_0080_0000, 4'd0);
    wait_head("sat_pos", 24'h7FFFFF, 1'b1, lat);
    send("sat_neg", 40'hFF_FF7F_FFFF, 4'd0);
    wait_head("sat_neg", 24'h800000, 1'b1, lat);
    send("sat_max", 40'h7F_FFFF_FFFF, 4'd15);
    wait_head("sat_max", 24'h7FFFFF, 1'b1, lat);
    cycle("sat_max_pop");

    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send("ovf_fill", PROD_W'(i), 4'd0);
    repeat (8) cycle("ovf_settle");
    chk("ovf:level",  64'(fifo_level), 64'(4));
    chk("ovf:drops",  64'(drop_count), 64'(2));
    chk("ovf:sticky", 64'(ovf_sticky), 64'(1));
    for (int k = 1; k <= 4; k++) begin
      chk("ovf:drain_order", 64'(out_data), 64'(k));
      out_ready = 1'b1;
      cycle("ovf_drain");
    end
    chk("ovf:drained", 64'(out_valid), 64'(0));
    ovf_clr = 1'b1;
    cycle("ovf_clr");
    ovf_clr = 1'b0;
    chk("clr:sticky", 64'(ovf_sticky), 64'(0));
    chk("clr:drops",  64'(drop_count), 64'(0));

    out_ready = 1'b0;
    raised    = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (q.size() == FIFO_DEPTH) raised = 1'b1;
      out_ready = raised;
      in_valid  = 1'b1;
      prod_in   = PROD_W'(32 + i);
      shift     = 4'd0;
      cycle("stream");
      if (raised) begin
        chk("stream:level", 64'(fifo_level), 64'(4));
        chk("stream:drops", 64'(drop_count), 64'(0));
      end
    end
    in_valid  = 1'b0;
    prod_in   = '0;
    out_ready = 1'b1;
    repeat (12) cycle("stream_drain");

    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      shift     = SHIFT_W'($urandom_range(0, 15));
      prod_in   = rand_prod();
      out_ready = ((k % 60) < 15) ? 1'b0 : ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 40) == 0);
      cycle("rand");
    end
    in_valid  = 1'b0;
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (12) cycle("rand_drain");

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send("rst_fill", PROD_W'(100 + i), 4'd0);
    repeat (3) cycle("rst_settle");
    chk("rst:pre_level", 64'(fifo_level), 64'(2));
    reset_n = 1'b0;
    model_reset();
    #2;
    check_all("rst_low");
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    check_all("rst_rel");
    out_ready = 1'b1;
    repeat (10) cycle("rst_idle");
    send("rst_next", 40'h00_0012_3450, 4'd4);
    wait_head("rst_next", 24'h012345, 1'b0, lat);
    chk("rst_next:clocks", 64'(lat), 64'(6));
    cycle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_round_sat.md
Name: mult_round_sat

Overview:
- Downstream consumer of the 8x32 signed pipelined multiplier (40-bit product, MULT_LAT-cycle latency, no valid/clken).
- Tracks sample validity and shift setting alongside the multiplier pipeline.
- Scales each product by an arithmetic right shift with round-half-up, saturates to signed 24 bits and buffers the result in a small FIFO with a valid/ready output.
- Overflow of the FIFO drops samples and is counted.

Parameters:
- PROD_W, 40: multiplier product width (signed).
- OUT_W, 24: output sample width (signed).
- MULT_LAT, 4: multiplier pipeline latency in clocks.
- SHIFT_W, 4: width of shift control (0..15).
- FIFO_DEPTH, 4: output buffer entries (power of 2).
- CNT_W, 16: drop counter width.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  high in the cycle operands are presented to the multiplier.
- shift  in  SHIFT_W  right-shift amount, sampled with in_valid.
- product  in  PROD_W  multiplier result.
- ovf_clr  in  1  clears ovf_sticky and drop_count.
- out_data  out  OUT_W  FIFO head sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid&&out_ready.
- out_sat  out  1  head sample was saturated.
- ovf_sticky  out  1  at least one sample dropped since the last clear.
- drop_count  out  CNT_W  dropped-sample count, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.

Behaviour:
- Reset (async assert, sync-safe release): tag pipe, stage register and FIFO are emptied. out_valid=0, out_data=0, out_sat=0, ovf_sticky=0, drop_count=0, fifo_level=0. In-flight samples are discarded.
- Tag pipe: MULT_LAT registers carry {in_valid, shift}. Tag exit is aligned with the product belonging to it. Shift changes mid-stream therefore apply per sample.
- Stage S1 (registered), when the tag valid is set:
  - shift==0: v = product sign-extended to PROD_W+1 bits.
  - else: v = (sext(product) + 2^(shift-1)) >>> shift, arithmetic shift, PROD_W+1-bit sum so no wrap at the max positive product.
  - Saturation: v > 2^(OUT_W-1)-1 gives 0x7FFFFF with sat=1; v < -2^(OUT_W-1) gives 0x800000 with sat=1; otherwise v[OUT_W-1:0] with sat=0.
- FIFO write: the S1 result {data, sat} is written the cycle after S1.
- Latency: in_valid sampled at edge N gives out_valid high after edge N+MULT_LAT+2 when the FIFO is empty (6 clocks at default). Throughput is 1 sample/clock.
- FIFO is first-word-fall-through. out_data/out_sat show the head while out_valid=1. Pop when out_valid&&out_ready.
- Full FIFO with a write and no pop: the sample is dropped, ovf_sticky is set, and drop_count increments, saturating at all-ones.
- Full FIFO with a write and a pop in the same cycle: accepted, no drop, level unchanged.
- Empty FIFO with a write and out_ready=1: the sample appears next cycle. No same-cycle bypass.
- ovf_clr and a drop in the same cycle: the drop wins. ovf_sticky=1 and drop_count=1.
- out_data holds its last value when the FIFO is empty. The consumer must ignore it when out_valid=0.
- Pointers wrap modulo FIFO_DEPTH. Level is tracked by a separate counter so full and empty are distinguishable.

Decomposition:
- Package mult_round_sat_pkg: OUT_MAX/OUT_MIN constants, default widths, and the saturate/round function for reuse by other scaling stages.
- Sub-module: sync_fifo_fwft (generic width/depth FWFT FIFO with full/empty/level). It is instantiated once with width OUT_W+1.

Test Plan:
- shift=0, product=0x00_0012_3456 with one in_valid pulse -> out_data=0x123456, out_sat=0, out_valid exactly 6 clocks after in_valid.
- shift=8, product=0x00_0000_0180 -> 0x000002. Then product=0xFF_FFFF_FE80 -> 0xFFFFFF (-1), confirming round-half-up.
- shift=0, product=0x00_0080_0000 -> 0x7FFFFF with out_sat=1. Then product=0xFF_FF7F_FFFF -> 0x800000 with out_sat=1. shift=15 with product=0x7F_FFFF_FFFF -> 0x7FFFFF with no internal wrap.
- out_ready=0 with 6 back-to-back valid samples 1..6 -> fifo_level=4, drop_count=2, ovf_sticky=1. Raising out_ready drains 1,2,3,4 in order. A subsequent ovf_clr -> both cleared.
- FIFO full with out_ready=1 and a continuous stream -> no drops, drop_count stays 0, order preserved, fifo_level stays 4.
- Assert reset_n low for 1 clock with 3 samples in flight and 2 in the FIFO -> all outputs return to reset values. No stale sample emerges after release. The next sample appears with normal 6-clock latency.
